// File: rtl/io_responder.sv
// io_responder: peripheral-side responder for the processor I/O bus.
// Input side: per-port holding registers, filled by valid/ready sources and
// read by req_in/addr_in. Output side: a tagged first-word-fall-through FIFO
// that takes out_en writes and drains them to a valid/ready sink.
// Optional feature macro: IO_RDCHK_EN adds a sticky udf flag that is set by
// reads of empty or nonexistent input ports.
module io_responder #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4,
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [AIW-1:0]           addr_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     out_en,
    input  logic [AOW-1:0]           addr_out,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOIN*NUBITS-1:0] src_data,
    input  logic [NUIOIN-1:0]        src_valid,
    output logic [NUIOIN-1:0]        src_ready,
    output logic [NUBITS-1:0]        snk_data,
    output logic [AOW-1:0]           snk_port,
    output logic                     snk_valid,
    input  logic                     snk_ready,
    output logic                     ovf
`ifdef IO_RDCHK_EN
    ,
    output logic                     udf
`endif
);

    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = AOW + NUBITS;
    localparam logic [AIW:0]  NIN_L   = (AIW + 1)'(NUIOIN);
    localparam logic [AOW:0]  NOU_L   = (AOW + 1)'(NUIOOU);
    localparam logic [CW-1:0] DEPTH_L = CW'(FDEPTH);

    // Input-side state
    logic [NUBITS-1:0] hold_r [NUIOIN];
    logic [NUIOIN-1:0] full_r;

    // Output FIFO state
    logic [EW-1:0]     mem_r [FDEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // Decoded per-cycle controls
    logic              rd_ok_s;
    logic              rd_empty_s;
    logic [NUBITS-1:0] rd_data_s;
    logic [NUIOIN-1:0] rd_clr_s;
    logic [NUIOIN-1:0] cap_s;
    logic              wr_ok_s;
    logic              fifo_full_s;
    logic              pop_s;
    logic              push_s;
    logic              ovf_set_s;
    logic [EW-1:0]     head_s;

    assign src_ready = ~full_r;
    assign snk_valid = (count_r != {CW{1'b0}});
    assign head_s    = mem_r[rd_ptr_r];

    // Read-side decode: selected hold value, per-port clear and capture strobes
    always_comb begin
        rd_ok_s    = ({1'b0, addr_in} < NIN_L);
        rd_data_s  = {NUBITS{1'b0}};
        rd_empty_s = 1'b1;
        rd_clr_s   = {NUIOIN{1'b0}};
        cap_s      = {NUIOIN{1'b0}};
        if (rd_ok_s) begin
            rd_data_s  = hold_r[addr_in];
            rd_empty_s = ~full_r[addr_in];
        end else begin
            rd_data_s  = {NUBITS{1'b0}};
            rd_empty_s = 1'b1;
        end
        for (int p = 0; p < NUIOIN; p++) begin
            cap_s[p] = src_valid[p] & ~full_r[p];
            if (req_in && rd_ok_s && (addr_in == AIW'(p))) begin
                rd_clr_s[p] = 1'b1;
            end else begin
                rd_clr_s[p] = 1'b0;
            end
        end
    end

    // FIFO push/pop decode; a full FIFO still accepts a push when it pops
    always_comb begin
        wr_ok_s     = ({1'b0, addr_out} < NOU_L);
        fifo_full_s = (count_r == DEPTH_L);
        pop_s       = snk_valid & snk_ready;
        push_s      = out_en & wr_ok_s & (~fifo_full_s | pop_s);
        ovf_set_s   = out_en & wr_ok_s & fifo_full_s & ~pop_s;
    end

    // Head presentation: fall-through from storage, forced to zero when empty
    always_comb begin
        if (snk_valid) begin
            snk_data = head_s[NUBITS-1:0];
            snk_port = head_s[EW-1:NUBITS];
        end else begin
            snk_data = {NUBITS{1'b0}};
            snk_port = {AOW{1'b0}};
        end
    end

    // Holding registers and full flags; a capture wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUIOIN; p++) begin
                hold_r[p] <= {NUBITS{1'b0}};
            end
            full_r <= {NUIOIN{1'b0}};
        end else begin
            for (int p = 0; p < NUIOIN; p++) begin
                if (cap_s[p]) begin
                    hold_r[p] <= src_data[p*NUBITS +: NUBITS];
                end else begin
                    hold_r[p] <= hold_r[p];
                end
            end
            full_r <= cap_s | (full_r & ~rd_clr_s);
        end
    end

    // Registered read data, updated only by a read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_in <= {NUBITS{1'b0}};
        end else if (req_in) begin
            io_in <= rd_data_s;
        end else begin
            io_in <= io_in;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FDEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {addr_out, io_out};
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag for writes dropped by a full FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (ovf_set_s) begin
            ovf <= 1'b1;
        end else begin
            ovf <= ovf;
        end
    end

`ifdef IO_RDCHK_EN
    // Sticky underflow flag for reads of empty or nonexistent ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            udf <= 1'b0;
        end else if (req_in && rd_empty_s) begin
            udf <= 1'b1;
        end else begin
            udf <= udf;
        end
    end
`else
    logic unused_rd_empty_s;
    assign unused_rd_empty_s = rd_empty_s;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: a reference model updated each cycle
// pushes expected read data and FIFO entries into queues that are popped and
// compared when the DUT produces them. Built with 3 input/3 output ports so
// that out-of-range addresses are reachable.
module tb_io_responder;

    localparam int NB  = 16;
    localparam int NI  = 3;
    localparam int NO  = 3;
    localparam int FD  = 4;
    localparam int AIW = 2;
    localparam int AOW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_in = 1'b0;
    logic [AIW-1:0]    addr_in = '0;
    logic [NB-1:0]     io_in;
    logic              out_en = 1'b0;
    logic [AOW-1:0]    addr_out = '0;
    logic [NB-1:0]     io_out = '0;
    logic [NI*NB-1:0]  src_data = '0;
    logic [NI-1:0]     src_valid = '0;
    logic [NI-1:0]     src_ready;
    logic [NB-1:0]     snk_data;
    logic [AOW-1:0]    snk_port;
    logic              snk_valid;
    logic              snk_ready = 1'b0;
    logic              ovf;
`ifdef IO_RDCHK_EN
    logic              udf;
`endif

    io_responder #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_port(snk_port), .snk_valid(snk_valid),
        .snk_ready(snk_ready), .ovf(ovf)
`ifdef IO_RDCHK_EN
        , .udf(udf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [NB-1:0]     hold_m [NI];
    logic [NI-1:0]     full_m;
    logic [NB-1:0]     io_m;
    logic              ovf_m;
    logic              udf_m;
    logic [NB-1:0]     rdq [$];
    logic [AOW+NB-1:0] fq  [$];

    task automatic model_reset();
        for (int p = 0; p < NI; p++) hold_m[p] = '0;
        full_m = '0;
        io_m   = '0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        rdq.delete();
        fq.delete();
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model with the current inputs, then check registered outputs after the edge.
    task automatic tick();
        logic [AOW+NB-1:0] e;
        logic [NI-1:0]     rdy_e;
        logic              pop;
        logic              was_full;
        logic              rd_pend;
        logic              cap;
        @(negedge clk);
        rdy_e = ~full_m;
        check("src_ready", src_ready, rdy_e);
        check("snk_valid", snk_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            e = fq[0];
            check("snk_data", snk_data, e[NB-1:0]);
            check("snk_port", snk_port, e[AOW+NB-1:NB]);
        end else begin
            check("snk_data_empty", snk_data, 0);
            check("snk_port_empty", snk_port, 0);
        end
        rd_pend = req_in;
        if (req_in) begin
            if (addr_in < NI) begin
                rdq.push_back(hold_m[addr_in]);
                if (!full_m[addr_in]) udf_m = 1'b1;
            end else begin
                rdq.push_back('0);
                udf_m = 1'b1;
            end
        end
        for (int p = 0; p < NI; p++) begin
            cap = src_valid[p] && !full_m[p];
            if (cap) begin
                hold_m[p] = src_data[p*NB +: NB];
                full_m[p] = 1'b1;
            end else if (req_in && (addr_in == p)) begin
                full_m[p] = 1'b0;
            end
        end
        pop      = (fq.size() != 0) && snk_ready;
        was_full = (fq.size() == FD);
        if (pop) void'(fq.pop_front());
        if (out_en && (addr_out < NO)) begin
            if (!was_full || pop) fq.push_back({addr_out, io_out});
            else ovf_m = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rd_pend) io_m = rdq.pop_front();
        check("io_in", io_in, io_m);
        check("ovf", ovf, ovf_m);
`ifdef IO_RDCHK_EN
        check("udf", udf, udf_m);
`endif
    endtask

    task automatic cap_port(input int p, input logic [NB-1:0] d);
        src_valid = '0;
        src_valid[p] = 1'b1;
        src_data[p*NB +: NB] = d;
        tick();
        src_valid = '0;
    endtask

    task automatic rd_port(input logic [AIW-1:0] a);
        req_in  = 1'b1;
        addr_in = a;
        tick();
        req_in  = 1'b0;
    endtask

    task automatic wr_port(input logic [AOW-1:0] a, input logic [NB-1:0] d);
        out_en   = 1'b1;
        addr_out = a;
        io_out   = d;
        tick();
        out_en   = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_io_in", io_in, 0);
        check("rst_snk_valid", snk_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_src_ready", src_ready, 3'b111);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: capture on port 1, read it back
        cap_port(1, 16'h1234);
        check("t1_ready_low", src_ready[1], 1'b0);
        rd_port(2'd1);
        check("t1_read", io_in, 16'h1234);
        tick();
        check("t1_ready_high", src_ready[1], 1'b1);

        // 2: capture and read of the same port in one cycle returns old data
        cap_port(0, 16'h00AA);
        rd_port(2'd0);
        src_valid[0] = 1'b1;
        src_data[NB-1:0] = 16'h00BB;
        req_in  = 1'b1;
        addr_in = 2'd0;
        tick();
        src_valid = '0;
        req_in    = 1'b0;
        check("t2_old", io_in, 16'h00AA);
        rd_port(2'd0);
        check("t2_new", io_in, 16'h00BB);
        rd_port(2'd0);
        rd_port(2'd3);
        check("t2_badaddr", io_in, 16'h0000);

        // 3: fill the FIFO, then overflow
        snk_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr_port(2'd1, NB'(i));
        check("t3_ovf_clear", ovf, 1'b0);
        wr_port(2'd1, 16'd5);
        check("t3_ovf_set", ovf, 1'b1);

        // 4: push into a full FIFO together with a pop, then drain
        snk_ready = 1'b1;
        wr_port(2'd0, 16'h0055);
        for (int i = 0; i < 5; i++) tick();

        // 5: streaming with random backpressure and invalid port writes
        for (int i = 0; i < 24; i++) begin
            snk_ready = 1'($urandom_range(0, 1));
            out_en    = 1'b1;
            addr_out  = (i % 7 == 5) ? 2'd3 : AOW'(i % 3);
            io_out    = NB'(16'h0100 + i);
            tick();
        end
        out_en    = 1'b0;
        snk_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // 6: asynchronous reset with entries held
        snk_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr_port(2'd2, NB'(16'h0A00 + i));
        cap_port(2, 16'hBEEF);
        rd_port(2'd2);
        #2;
        rst = 1'b0;
        #1;
        check("t6_snk_valid", snk_valid, 1'b0);
        check("t6_io_in", io_in, 16'h0000);
        check("t6_ovf", ovf, 1'b0);
        check("t6_src_ready", src_ready, 3'b111);
        check("t6_snk_data", snk_data, 16'h0000);
        model_reset();
        #1;
        rst = 1'b1;
        tick();
        rd_port(2'd0);
`ifdef IO_RDCHK_EN
        check("t6_udf", udf, 1'b1);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
